clk_div_counter: RTL

- Parameterised modulo counter and clock divider for lab designs. It generalises the single-bit CLK-to-D0 toggle divider into a WIDTH-bit counter.
- The counter supports a runtime-programmable terminal value, up/down counting, count enable and synchronous load.
- Outputs are the count value, a one-cycle terminal-count pulse, and a divided square wave D0.
- It sits directly on the board clock and feeds LED/7-segment logic or downstream enables.

---
 rtl/clk_div_counter.sv | 40 ++++
 1 files changed

// File: rtl/clk_div_counter.sv
// clk_div_counter: up/down modulo-(MAX+1) counter with load, TC pulse and D0 divider; in CLK RST EN LOAD LOAD_VAL DIR MAX, out Q TC D0
module clk_div_counter #(
  parameter int WIDTH   = 4,
  parameter bit D0_INIT = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             DIR,
  input  logic [WIDTH-1:0] MAX,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             D0
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d, d0_q, d0_d, wrap;
  always_comb begin
    wrap = !LOAD && EN && (DIR ? (q_q >= MAX) : (q_q == '0));
    q_d  = LOAD ? LOAD_VAL : !EN ? q_q : wrap ? (DIR ? '0 : MAX) : DIR ? q_q + ONE : q_q - ONE;
    tc_d = wrap;
    d0_d = d0_q ^ wrap;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q  <= '0;
      tc_q <= 1'b0;
      d0_q <= D0_INIT;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
      d0_q <= d0_d;
    end
  end
  assign Q  = q_q;
  assign TC = tc_q;
  assign D0 = d0_q;
endmodule
